// File: rtl/ghash_tag_engine.sv
// Iterative GHASH accumulator: bit-serial GF(2^128) multiply (one bit per cycle),
// then tag = S ^ E(K,J0). Bit 0 of every [0:127] vector is the x^0 coefficient.
module ghash_tag_engine (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic [0:127] i_ekj0,
  input  logic         i_valid,
  input  logic [0:127] i_block,
  input  logic         i_last,
  output logic         o_ready,
  output logic         o_busy,
  output logic [0:127] o_tag,
  output logic         o_tag_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_MUL, ST_FINAL} state_e;

  // Reduction constant for x^128 + x^7 + x^2 + x + 1 in reflected bit order.
  localparam logic [0:127] R = {8'he1, 120'd0};

  state_e       state_q, state_d;
  logic [0:127] h_q, h_d;
  logic [0:127] s_q, s_d;
  logic [0:127] x_q, x_d;
  logic [0:127] v_q, v_d;
  logic [0:127] z_q, z_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic [0:127] tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic [0:127] z_step, v_step;

  always_comb begin
    // z_step uses the pre-shift V of this iteration.
    z_step = x_q[cnt_q] ? (z_q ^ v_q) : z_q;
    v_step = v_q[127] ? ({1'b0, v_q[0:126]} ^ R) : {1'b0, v_q[0:126]};

    state_d     = state_q;
    h_d         = h_q;
    s_d         = s_q;
    x_d         = x_q;
    v_d         = v_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;

    if (i_start) begin
      h_d     = i_h;
      s_d     = '0;
      cnt_d   = '0;
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (i_valid && ready_q) begin
            x_d     = s_q ^ i_block;
            v_d     = h_q;
            z_d     = '0;
            cnt_d   = '0;
            last_d  = i_last;
            state_d = ST_MUL;
          end
        end
        ST_MUL: begin
          z_d   = z_step;
          v_d   = v_step;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd127) begin
            s_d     = z_step;
            state_d = last_q ? ST_FINAL : ST_WAIT;
          end
        end
        ST_FINAL: begin
          tag_d       = s_q ^ i_ekj0;
          tag_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Handshake/status outputs are registered decodes of the next state.
    ready_d = (state_d == ST_WAIT);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      s_q         <= '0;
      x_q         <= '0;
      v_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      x_q         <= x_d;
      v_q         <= v_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_tag       = tag_q;
  assign o_tag_valid = tag_valid_q;

endmodule

// File: doc/ghash_tag_engine.md
# ghash_tag_engine

Iterative GHASH accumulator and tag finaliser for the AES-GCM datapath. Consumes 128-bit blocks (AAD, then ciphertext, then the length block, all zero-padded by the producer) over a valid/ready handshake. Computes S = ((S ^ block) • H) in GF(2^128) with a bit-serial multiplier, then emits tag = S ^ E(K,J0). It sits directly downstream of the AES counter-mode output, replacing the flat combinational multiplier chain that overflows the Basys3 LUT budget; its o_tag feeds the display stage.

## Interface
- No parameters; width fixed at 128 (GCM block), bit index [0:127], bit 0 = MSB of byte 0 = x^0 coefficient.
- clk  input  1  single clock; all state on posedge clk.
- clr  input  1  synchronous, active-high reset.
- i_start  input  1  begin a new tag computation; latches i_h, clears S.
- i_h  input  [0:127]  hash subkey H = E(K, 0^128), sampled when i_start accepted.
- i_ekj0  input  [0:127]  E(K, J0), sampled in the FINAL cycle.
- i_valid  input  1  i_block/i_last valid.
- i_block  input  [0:127]  next GHASH input block.
- i_last  input  1  marks the length block; qualified by i_valid.
- o_ready  output  1  block accepted when i_valid && o_ready.
- o_busy  output  1  high in any state other than IDLE.
- o_tag  output  [0:127]  final tag; holds until next i_start or clr.
- o_tag_valid  output  1  one-cycle pulse when o_tag updates.

## Operation
- States: IDLE, WAIT, MUL, FINAL.
- IDLE: o_ready=0. i_start -> H<=i_h, S<=0, go WAIT.
- WAIT: o_ready=1. On accept: X<=S^i_block, V<=H, Z<=0, cnt<=0, last_q<=i_last, go MUL.
- MUL: one iteration per cycle, 128 cycles (cnt 0..127). Each cycle: if X[cnt], Z<=Z^V. If V[127]==0, V<={1'b0,V[0:126]}; else V<={1'b0,V[0:126]}^R, where R=0xE1 followed by 120 zeros. The Z update uses pre-shift V.
- On cnt==127: S<=final Z. Go FINAL if last_q, else WAIT.
- FINAL: o_tag<=S^i_ekj0, o_tag_valid<=1, go IDLE.
- i_start has priority in every state: aborts any computation, reloads H, clears S and cnt, and goes WAIT. o_tag is not cleared by a restart; o_tag_valid is not pulsed for an aborted run.
- Empty message is legal: a single length block with i_last=1.
- i_valid while o_ready=0 is ignored. The producer must hold i_block/i_last until accepted.
- GF arithmetic is pure XOR/shift; no carries, all widths exactly 128.

## Timing
- Reset (clr high at an edge):
  - state=IDLE.
  - o_ready=0, o_busy=0, o_tag=0, o_tag_valid=0.
  - H, S, X, V, Z, cnt=0.
- clr mid-MUL discards the block; no tag is produced.
- i_start at edge t -> WAIT, o_ready=1 in cycle t+1.
- Block accepted at edge t -> MUL during cycles t+1..t+128. S is valid after edge t+128.
  - Non-last block: o_ready=1 again in cycle t+129. Throughput is one block per 129 cycles with back-to-back valid.
  - Last block: FINAL in cycle t+129; o_tag and o_tag_valid visible in cycle t+130; o_busy=0 from t+130.
- o_ready is a registered state decode and never depends combinationally on i_valid.
- Simultaneous i_start and i_valid in WAIT: the start wins and the block is not accepted.

## Test plan
- Reset/idle:
  - Assert clr for 2 cycles with random inputs -> all outputs 0.
  - i_valid=1 in IDLE -> o_ready stays 0 and no state change.
- Multiply identity:
  - Stimulus: H=0x80000000_00000000_00000000_00000000 (element 1), ekj0=0, one block 0x0123456789abcdef_fedcba9876543210 with i_last.
  - Response: o_tag equals the block; o_tag_valid at exactly accept+130.
- NIST GCM TC1 (empty P, empty A):
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ekj0=58e2fccefa7e3061367f1d57a4e7455a, single length block of 0 with i_last.
  - Response: tag 58e2fccefa7e3061367f1d57a4e7455a.
- NIST GCM TC2:
  - Stimulus: same H/ekj0; blocks 0388dace60b6a392f328c2b971b2fe78, then 00000000000000000000000000000080 with i_last.
  - Response: tag ab6e47d42cec13bdf53a67b21257bddf. Second o_ready rises 129 cycles after the first accept.
- Backpressure/hold:
  - Drop i_valid for random gaps in WAIT -> identical TC2 tag.
  - Change i_block while o_ready=0 -> no effect on the tag.
- Abort:
  - i_start at MUL cnt=60 of TC2, then rerun TC1 -> no pulse for the aborted run; TC1 tag correct.
  - clr mid-MUL -> reset values next cycle.
